// File: rtl/dice_roll_sequencer_if.sv
// Bundle of the dice sequencer's input requests and its display/result outputs.
// The master side (host, buttons and prescaler) drives the requests; the
// sequencer is the slave.
interface dice_roll_sequencer_if;
    logic       tick;
    logic [6:0] btn_req;
    logic       host_req;
    logic [2:0] host_die;
    logic       host_ack;
    logic       busy;
    logic [3:0] digit10;
    logic [3:0] digit1;
    logic       blank10;
    logic       show;
    logic [6:0] result;
    logic       result_valid;

    modport master (
        output tick, btn_req, host_req, host_die,
        input  host_ack, busy, digit10, digit1, blank10, show, result, result_valid
    );

    modport slave (
        input  tick, btn_req, host_req, host_die,
        output host_ack, busy, digit10, digit1, blank10, show, result, result_valid
    );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Electronic dice: accepts a roll request from a button edge or a host
// handshake, free-runs a 1..N roll counter every clock while spinning, animates
// the BCD display on prescaler ticks, then settles and shows the result for a
// fixed number of ticks.
module dice_roll_sequencer #(
    parameter int unsigned SPIN_TICKS = 16,
    parameter int unsigned SHOW_TICKS = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    dice_roll_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SPIN = 2'd1,
        S_SHOW = 2'd2
    } state_e;

    localparam logic [7:0] SPIN_LOAD = 8'(SPIN_TICKS);
    localparam logic [7:0] SHOW_LOAD = 8'(SHOW_TICKS);

    state_e     state_q, state_d;
    logic [6:0] btn_q;
    logic       armed_q;
    logic [7:0] die_n_q, die_n_d;
    logic [7:0] roll_q, roll_d;
    logic [3:0] roll_tens_q, roll_tens_d;
    logic [3:0] roll_ones_q, roll_ones_d;
    logic [7:0] spin_q, spin_d;
    logic [7:0] show_q, show_d;
    logic [6:0] result_q, result_d;
    logic [3:0] digit10_q, digit10_d;
    logic [3:0] digit1_q, digit1_d;
    logic       blank10_q, blank10_d;
    logic       rv_q, rv_d;

    logic [6:0] btn_rise;
    logic [2:0] btn_code;
    logic       can_accept;
    logic       btn_event;
    logic       host_take;
    logic       accept;
    logic [2:0] die_code;

    // Die code to number of sides.
    function automatic logic [7:0] side_count(input logic [2:0] code);
        case (code)
            3'd0:    side_count = 8'd4;
            3'd1:    side_count = 8'd6;
            3'd2:    side_count = 8'd8;
            3'd3:    side_count = 8'd10;
            3'd4:    side_count = 8'd12;
            3'd5:    side_count = 8'd20;
            default: side_count = 8'd100;
        endcase
    endfunction

    // Request arbitration: registered-edge buttons beat the host, lowest button
    // index wins; armed_q masks the first cycle after reset so a held button is
    // not seen as an edge.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise a path that skips the assignment infers a latch.
        btn_code = 3'd0;
        btn_rise = armed_q ? (bus.btn_req & ~btn_q) : 7'd0;
        for (int i = 6; i >= 0; i--) begin
            if (btn_rise[i]) btn_code = 3'(i);
        end
        can_accept = !rst && (state_q != S_SPIN);
        btn_event  = can_accept && (|btn_rise);
        host_take  = can_accept && !(|btn_rise) && bus.host_req;
        accept     = btn_event || (host_take && (bus.host_die != 3'd7));
        die_code   = btn_event ? btn_code : bus.host_die;
    end

    // Next-state and datapath: accept restarts a roll, SPIN counts rolls and
    // ticks down to the settle, SHOW ticks down back to IDLE.
    always_comb begin
        state_d     = state_q;
        die_n_d     = die_n_q;
        roll_d      = roll_q;
        roll_tens_d = roll_tens_q;
        roll_ones_d = roll_ones_q;
        spin_d      = spin_q;
        show_d      = show_q;
        result_d    = result_q;
        digit10_d   = digit10_q;
        digit1_d    = digit1_q;
        blank10_d   = blank10_q;
        rv_d        = 1'b0;

        case (state_q)
            S_IDLE, S_SHOW: begin
                if (accept) begin
                    die_n_d     = side_count(die_code);
                    roll_d      = 8'd1;
                    roll_tens_d = 4'd0;
                    roll_ones_d = 4'd1;
                    spin_d      = SPIN_LOAD;
                    state_d     = S_SPIN;
                end else if (state_q == S_SHOW && bus.tick) begin
                    show_d = (show_q != 8'd0) ? show_q - 8'd1 : 8'd0;
                    if (show_q <= 8'd1) state_d = S_IDLE;
                end
            end
            S_SPIN: begin
                // Binary and BCD roll counters advance together, wrapping N -> 1.
                if (roll_q >= die_n_q) begin
                    roll_d      = 8'd1;
                    roll_tens_d = 4'd0;
                    roll_ones_d = 4'd1;
                end else begin
                    roll_d = roll_q + 8'd1;
                    if (roll_ones_q == 4'd9) begin
                        roll_ones_d = 4'd0;
                        roll_tens_d = (roll_tens_q == 4'd9) ? 4'd0 : roll_tens_q + 4'd1;
                    end else begin
                        roll_ones_d = roll_ones_q + 4'd1;
                    end
                end
                if (bus.tick) begin
                    spin_d    = (spin_q != 8'd0) ? spin_q - 8'd1 : 8'd0;
                    digit10_d = roll_tens_q;
                    digit1_d  = roll_ones_q;
                    blank10_d = (roll_tens_q == 4'd0) && (roll_q != 8'd100);
                    if (spin_q <= 8'd1) begin
                        result_d = roll_q[6:0];
                        rv_d     = 1'b1;
                        show_d   = SHOW_LOAD;
                        state_d  = S_SHOW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            btn_q       <= 7'd0;
            armed_q     <= 1'b0;
            die_n_q     <= 8'd0;
            roll_q      <= 8'd0;
            roll_tens_q <= 4'd0;
            roll_ones_q <= 4'd0;
            spin_q      <= 8'd0;
            show_q      <= 8'd0;
            result_q    <= 7'd0;
            digit10_q   <= 4'd0;
            digit1_q    <= 4'd0;
            blank10_q   <= 1'b1;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= bus.btn_req;
            armed_q     <= 1'b1;
            die_n_q     <= die_n_d;
            roll_q      <= roll_d;
            roll_tens_q <= roll_tens_d;
            roll_ones_q <= roll_ones_d;
            spin_q      <= spin_d;
            show_q      <= show_d;
            result_q    <= result_d;
            digit10_q   <= digit10_d;
            digit1_q    <= digit1_d;
            blank10_q   <= blank10_d;
            rv_q        <= rv_d;
        end
    end

    assign bus.host_ack     = host_take;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.show         = (state_q != S_IDLE);
    assign bus.digit10      = digit10_q;
    assign bus.digit1       = digit1_q;
    assign bus.blank10      = blank10_q;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Bench for dice_roll_sequencer: directed scenarios plus randomized rolls,
// checked against a roll model built from the tick log and accept cycles.
module tb_dice_roll_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dice_roll_sequencer_if bus ();

    dice_roll_sequencer #(.SPIN_TICKS(4), .SHOW_TICKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit tick_en = 1'b1;
    int last_res = 0;
    int sides [7] = '{4, 6, 8, 10, 12, 20, 100};

    // Monitor state, written only by the negedge monitor.
    int   tick_log [$];
    int   ack_cnt  = 0;
    int   ack_cyc  = -1;
    int   rv_cnt   = 0;
    int   rv_cyc   = -1;
    int   rise_cnt = 0;
    logic prev_busy = 1'b0;

    // Sample DUT outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (bus.tick === 1'b1) tick_log.push_back(cyc);
        if (bus.host_ack === 1'b1) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (bus.result_valid === 1'b1) begin
            rv_cnt++;
            rv_cyc = cyc;
        end
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) rise_cnt++;
        prev_busy = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; the tick strobe comes every 8 cycles while enabled.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.tick = tick_en && (cyc % 8 == 0);
    endtask

    task automatic goto_phase(input int p);
        while (cyc % 8 != p) step();
    endtask

    function automatic int nth_tick_after(input int a, input int n);
        int k = 0;
        foreach (tick_log[i]) begin
            if (tick_log[i] > a) begin
                k++;
                if (k == n) return tick_log[i];
            end
        end
        return -1;
    endfunction

    // Roll model: settle is the 4th tick after accept, result = 1 + ((D-1) mod N).
    task automatic check_roll(input string tag, input int a, input int n, input int rv_before);
        int budget;
        int settle;
        int r;
        budget = 0;
        while (rv_cnt == rv_before && budget < 400) begin
            step();
            budget++;
        end
        check({tag, "_rv_count"}, rv_cnt - rv_before, 1);
        settle = nth_tick_after(a, 4);
        r = 1 + ((settle - a - 1) % n);
        check({tag, "_rv_cycle"}, rv_cyc, settle + 1);
        check({tag, "_result"}, bus.result, r);
        check({tag, "_digit10"}, bus.digit10, (r == 100) ? 0 : r / 10);
        check({tag, "_digit1"}, bus.digit1, r % 10);
        check({tag, "_blank10"}, bus.blank10, (r < 10) ? 1 : 0);
        last_res = r;
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        while (bus.busy === 1'b1 && budget < 400) begin
            step();
            budget++;
        end
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int a, a2, s, rv0, rv1, ak0, r0, prev;
        bus.tick     = 1'b0;
        bus.btn_req  = 7'd0;
        bus.host_req = 1'b1;
        bus.host_die = 3'd0;
        rst          = 1'b1;

        // Reset state, with a host request present that must not be acked.
        step();
        step();
        check("rst_busy", bus.busy, 0);
        check("rst_show", bus.show, 0);
        check("rst_digit10", bus.digit10, 0);
        check("rst_digit1", bus.digit1, 0);
        check("rst_blank10", bus.blank10, 1);
        check("rst_result", bus.result, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_ack", bus.host_ack, 0);
        bus.host_req = 1'b0;
        rst = 1'b0;
        step();

        // Basic d4 button roll with D = 29.
        goto_phase(3);
        rv0 = rv_cnt;
        a = cyc;
        bus.btn_req = 7'b0000001;
        step();
        check("s1_busy", bus.busy, 1);
        check("s1_show", bus.show, 1);
        check_roll("s1", a, 4, rv0);
        s = nth_tick_after(a, 4);
        wait_idle("s1");
        check("s1_idle_cycle", cyc, nth_tick_after(s, 3) + 1);
        check("s1_rv_once", rv_cnt - rv0, 1);
        bus.btn_req = 7'd0;
        step();

        // Host d100 roll with D = 100: ticks held off, then resumed.
        tick_en = 1'b0;
        goto_phase(4);
        rv0 = rv_cnt;
        ak0 = ack_cnt;
        bus.host_die = 3'd6;
        bus.host_req = 1'b1;
        a = cyc;
        step();
        bus.host_req = 1'b0;
        check("s2_ack_count", ack_cnt - ak0, 1);
        check("s2_ack_cycle", ack_cyc, a);
        while (cyc < a + 75) step();
        tick_en = 1'b1;
        step();
        check_roll("s2", a, 100, rv0);
        wait_idle("s2");

        // Button and host collide: button wins, host acked in first SHOW cycle.
        goto_phase(2);
        rv0 = rv_cnt;
        ak0 = ack_cnt;
        bus.btn_req  = 7'b0000100;
        bus.host_die = 3'd1;
        bus.host_req = 1'b1;
        a = cyc;
        step();
        check("s3_busy", bus.busy, 1);
        check("s3_no_ack", ack_cnt - ak0, 0);
        check_roll("s3", a, 8, rv0);
        prev = last_res;
        check("s3_ack_count", ack_cnt - ak0, 1);
        check("s3_ack_cycle", ack_cyc, rv_cyc);
        bus.host_req = 1'b0;
        a2 = ack_cyc;
        rv1 = rv_cnt;
        check("s3_restart_busy", bus.busy, 1);
        check("s3_result_hold", bus.result, prev);
        check_roll("s3b", a2, 6, rv1);
        wait_idle("s3");
        bus.btn_req = 7'd0;
        step();

        // Button rising during SPIN is dropped; a held button fires once.
        goto_phase(5);
        rv0 = rv_cnt;
        r0 = rise_cnt;
        bus.btn_req = 7'b0000010;
        a = cyc;
        step();
        repeat (5) step();
        bus.btn_req = 7'b0001010;
        check_roll("s4", a, 6, rv0);
        while (cyc < a + 100) step();
        check("s4_one_accept", rise_cnt - r0, 1);
        check("s4_rv_once", rv_cnt - rv0, 1);
        check("s4_idle", bus.busy, 0);
        bus.btn_req = 7'd0;
        step();

        // Illegal host code: acked, otherwise ignored.
        ak0 = ack_cnt;
        r0 = rise_cnt;
        bus.host_die = 3'd7;
        bus.host_req = 1'b1;
        a = cyc;
        step();
        bus.host_req = 1'b0;
        check("s5_ack_count", ack_cnt - ak0, 1);
        check("s5_ack_cycle", ack_cyc, a);
        repeat (20) step();
        check("s5_busy", bus.busy, 0);
        check("s5_no_start", rise_cnt - r0, 0);
        check("s5_result", bus.result, last_res);

        // Randomized rolls, requested from IDLE or mid-SHOW.
        for (int k = 0; k < 8; k++) begin
            int  d;
            int  g;
            int  mask;
            bit  use_host;
            d = $urandom_range(0, 6);
            use_host = 1'($urandom_range(0, 1));
            g = $urandom_range(0, 40);
            mask = $urandom_range(1, 127);
            repeat (g) step();
            rv0 = rv_cnt;
            ak0 = ack_cnt;
            prev = last_res;
            if (use_host) begin
                bus.host_die = 3'(d);
                bus.host_req = 1'b1;
                a = cyc;
                step();
                bus.host_req = 1'b0;
                check("rnd_ack_cycle", ack_cyc, a);
            end else begin
                d = 0;
                while (((mask >> d) & 1) == 0) d++;
                bus.btn_req = 7'(mask);
                a = cyc;
                step();
                bus.btn_req = 7'd0;
                check("rnd_no_ack", ack_cnt - ak0, 0);
            end
            check("rnd_busy", bus.busy, 1);
            check("rnd_result_hold", bus.result, prev);
            check_roll("rnd", a, sides[d], rv0);
        end
        wait_idle("rnd");
        step();

        // Reset mid-SPIN: outputs clear on the edge, no result, host dropped,
        // buttons held through reset do not fire.
        goto_phase(1);
        rv0 = rv_cnt;
        ak0 = ack_cnt;
        r0 = rise_cnt;
        bus.btn_req = 7'b0010000;
        step();
        repeat (10) step();
        check("s7_spinning", bus.busy, 1);
        rst = 1'b1;
        bus.host_die = 3'd2;
        bus.host_req = 1'b1;
        bus.btn_req = 7'b0110000;
        step();
        check("s7_busy", bus.busy, 0);
        check("s7_show", bus.show, 0);
        check("s7_digit10", bus.digit10, 0);
        check("s7_digit1", bus.digit1, 0);
        check("s7_blank10", bus.blank10, 1);
        check("s7_result", bus.result, 0);
        check("s7_rv", bus.result_valid, 0);
        check("s7_ack", bus.host_ack, 0);
        rst = 1'b0;
        bus.host_req = 1'b0;
        repeat (60) step();
        check("s7_no_rv", rv_cnt - rv0, 0);
        check("s7_no_ack", ack_cnt - ak0, 0);
        check("s7_one_start", rise_cnt - r0, 1);
        check("s7_idle", bus.busy, 0);
        bus.btn_req = 7'd0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
